// File: rtl/ready_valid_pipeline.sv
// Elastic payload pipeline: a skid-buffered input slice, a stall-as-a-whole
// register core, and a skid-buffered output slice. The slices isolate the
// core's combinational enable from the block ports, so u_ready is always a
// register output.
//
// Handshake (every port, internal and external): a beat transfers exactly at
// a rising clk edge where valid and ready are both high. A producer holding
// valid=1 keeps data stable until that edge; ready may be high with valid low.

// Two-entry register slice: output register plus skid register.
module pipeline_insert #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] u_data,
  input  logic                  u_valid,
  output logic                  u_ready,
  output logic [DATA_WIDTH-1:0] d_data,
  output logic                  d_valid,
  input  logic                  d_ready
);
  logic [DATA_WIDTH-1:0] skid_data;
  logic                  skid_valid;
  logic                  accept;

  // Ready depends only on the skid flag, so it is a pure register output.
  assign u_ready = !skid_valid;
  assign accept  = u_valid && !skid_valid;

  // Refill the output register from skid first (oldest beat), else from the
  // input; a beat arriving while the output is stalled parks in the skid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d_valid    <= 1'b0;
      d_data     <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (!d_valid || d_ready) begin
      if (skid_valid) begin
        d_data     <= skid_data;
        d_valid    <= 1'b1;
        skid_valid <= 1'b0;
      end else if (accept) begin
        d_data  <= u_data;
        d_valid <= 1'b1;
      end else begin
        d_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_data  <= u_data;
      skid_valid <= 1'b1;
    end
  end
endmodule

// Core shift pipeline: every stage advances together under one enable.
module pipeline #(
  parameter int DATA_WIDTH      = 32,
  parameter int PIPELINE_STAGES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] u_data,
  input  logic                  u_valid,
  output logic                  u_ready,
  output logic [DATA_WIDTH-1:0] d_data,
  output logic                  d_valid,
  input  logic                  d_ready
);
  logic [DATA_WIDTH-1:0]      stage_data [PIPELINE_STAGES];
  logic [PIPELINE_STAGES-1:0] stage_valid;
  logic                       en;

  // Advance when the last stage drains or holds a bubble; otherwise freeze.
  assign en      = d_ready || !stage_valid[PIPELINE_STAGES-1];
  assign u_ready = en;
  assign d_data  = stage_data[PIPELINE_STAGES-1];
  assign d_valid = stage_valid[PIPELINE_STAGES-1];

  // Shift all stages by one on enable; stage 0 captures the upstream beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage_valid <= '0;
      for (int i = 0; i < PIPELINE_STAGES; i++) stage_data[i] <= '0;
    end else if (en) begin
      stage_data[0]  <= u_data;
      stage_valid[0] <= u_valid;
      for (int i = 1; i < PIPELINE_STAGES; i++) begin
        stage_data[i]  <= stage_data[i-1];
        stage_valid[i] <= stage_valid[i-1];
      end
    end
  end
endmodule

// Top: input slice -> core -> output slice.
module ready_valid_pipeline #(
  parameter int DATA_WIDTH      = 32,
  parameter int PIPELINE_STAGES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] u_data,
  input  logic                  u_valid,
  output logic                  u_ready,
  output logic [DATA_WIDTH-1:0] d_data,
  output logic                  d_valid,
  input  logic                  d_ready
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] core_data;
  logic                  core_valid;
  logic                  core_ready;

  pipeline_insert #(.DATA_WIDTH(DATA_WIDTH)) u_in_slice (
    .clk     (clk),
    .rst_n   (rst_n),
    .u_data  (u_data),
    .u_valid (u_valid),
    .u_ready (u_ready),
    .d_data  (in_data),
    .d_valid (in_valid),
    .d_ready (in_ready)
  );

  pipeline #(.DATA_WIDTH(DATA_WIDTH), .PIPELINE_STAGES(PIPELINE_STAGES)) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .u_data  (in_data),
    .u_valid (in_valid),
    .u_ready (in_ready),
    .d_data  (core_data),
    .d_valid (core_valid),
    .d_ready (core_ready)
  );

  pipeline_insert #(.DATA_WIDTH(DATA_WIDTH)) u_out_slice (
    .clk     (clk),
    .rst_n   (rst_n),
    .u_data  (core_data),
    .u_valid (core_valid),
    .u_ready (core_ready),
    .d_data  (d_data),
    .d_valid (d_valid),
    .d_ready (d_ready)
  );
endmodule

// File: tb/tb_ready_valid_pipeline.sv
// Bench for ready_valid_pipeline: randomized streams against an in-order
// FIFO reference (every accepted input must emerge once, in order), plus
// latency, capacity, stall-hold and reset checks.
module tb_ready_valid_pipeline;
  localparam int DW = 32;
  localparam int NS = 4;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] u_data;
  logic          u_valid;
  logic          u_ready;
  logic [DW-1:0] d_data;
  logic          d_valid;
  logic          d_ready;

  always #5 clk = ~clk;

  ready_valid_pipeline #(.DATA_WIDTH(DW), .PIPELINE_STAGES(NS)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .u_data  (u_data),
    .u_valid (u_valid),
    .u_ready (u_ready),
    .d_data  (d_data),
    .d_valid (d_valid),
    .d_ready (d_ready)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard (reference model) ----------------
  // Inputs and outputs sampled at negedge: the values that the next rising
  // edge will see, since the driver changes inputs just after posedge.
  logic [DW-1:0] exp_q[$];
  int            out_count = 0;
  logic [DW-1:0] last_out  = '0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data  = '0;

  always @(negedge clk) begin
    if (prev_stall) begin
      check("hold_d_valid", d_valid, 1);
      check("hold_d_data", d_data, prev_data);
    end
    prev_stall = rst_n && d_valid && !d_ready;
    prev_data  = d_data;
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (d_valid && d_ready) begin
        check("beat_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("d_data", d_data, exp_q.pop_front());
        out_count++;
        last_out = d_data;
      end
      if (u_valid && u_ready) exp_q.push_back(u_data);
    end
  end

  // ---------------- driver ----------------
  logic fire;
  int   idx, gap, stall, base, first_c, last_c;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; u_valid = 1'b0; u_data = '0; d_ready = 1'b0;
    repeat (3) next_cycle();
    @(negedge clk);
    check("rst_d_valid", d_valid, 0);
    check("rst_d_data", d_data, 0);
    check("rst_u_ready", u_ready, 1);
    next_cycle();
    rst_n = 1'b1;

    // Full-rate stream 0..99: latency and one beat per cycle.
    idx = 0; first_c = -1; last_c = -1; base = out_count;
    for (int c = 0; c < 400 && (out_count - base) < 100; c++) begin
      u_valid = (idx < 100); u_data = DW'(idx); d_ready = 1'b1;
      @(negedge clk);
      if (d_valid && first_c < 0) first_c = c;
      if (d_valid && d_ready) last_c = c;
      fire = u_valid && u_ready;
      next_cycle();
      if (fire) idx++;
    end
    u_valid = 1'b0;
    check("stream_latency", first_c, NS + 2);
    check("stream_rate", last_c - first_c, 99);
    check("stream_count", out_count - base, 100);

    // Stream 0..99 with random bubbles and random downstream stalls.
    idx = 0; gap = 0; stall = 0; base = out_count;
    for (int c = 0; c < 3000 && (idx < 100 || exp_q.size() != 0); c++) begin
      u_valid = (idx < 100) && (gap == 0); u_data = DW'(idx);
      if (stall > 0) begin
        d_ready = 1'b0; stall--;
      end else begin
        d_ready = 1'b1;
        if ($urandom_range(0, 3) == 0) stall = $urandom_range(0, 3);
      end
      @(negedge clk);
      fire = u_valid && u_ready;
      next_cycle();
      if (fire) begin idx++; gap = $urandom_range(0, 3); end
      else if (gap > 0) gap--;
    end
    u_valid = 1'b0; d_ready = 1'b1;
    check("random_accepted", idx, 100);
    check("random_count", out_count - base, 100);
    check("random_drained", exp_q.size(), 0);

    // Downstream held off: block fills to its storage capacity.
    idx = 0; d_ready = 1'b0; base = out_count;
    for (int c = 0; c < 30; c++) begin
      u_valid = (idx < 10); u_data = DW'(idx);
      @(negedge clk);
      fire = u_valid && u_ready;
      next_cycle();
      if (fire) idx++;
    end
    @(negedge clk);
    check("fill_accepted", idx, NS + 4);
    check("fill_u_ready", u_ready, 0);
    check("fill_d_valid", d_valid, 1);
    check("fill_d_data", d_data, 0);

    // Release: stored beats then remaining input come out in order.
    next_cycle();
    d_ready = 1'b1;
    for (int c = 0; c < 200 && (idx < 10 || exp_q.size() != 0); c++) begin
      u_valid = (idx < 10); u_data = DW'(idx);
      @(negedge clk);
      fire = u_valid && u_ready;
      next_cycle();
      if (fire) idx++;
    end
    u_valid = 1'b0;
    check("release_count", out_count - base, 10);
    check("release_last", last_out, 9);

    // Fill, then a one-cycle reset pulse with an offered beat.
    d_ready = 1'b0; idx = 0;
    for (int c = 0; c < 30; c++) begin
      u_valid = 1'b1; u_data = DW'(200 + idx);
      @(negedge clk);
      fire = u_valid && u_ready;
      next_cycle();
      if (fire) idx++;
    end
    rst_n = 1'b0; u_valid = 1'b1; u_data = DW'(77); d_ready = 1'b1;
    next_cycle();
    rst_n = 1'b1; u_valid = 1'b0;
    @(negedge clk);
    check("pulse_d_valid", d_valid, 0);
    check("pulse_u_ready", u_ready, 1);
    base = out_count;
    next_cycle();
    u_valid = 1'b1; u_data = DW'(55);
    for (int c = 0; c < 50 && (out_count - base) < 1; c++) begin
      @(negedge clk);
      fire = u_valid && u_ready;
      next_cycle();
      if (fire) u_valid = 1'b0;
    end
    u_valid = 1'b0;
    repeat (NS + 4) next_cycle();
    check("pulse_count", out_count - base, 1);
    check("pulse_data", last_out, 55);

    // Alternating downstream ready with continuous input.
    idx = 0; base = out_count;
    for (int c = 0; c < 500 && (idx < 40 || exp_q.size() != 0); c++) begin
      u_valid = (idx < 40); u_data = DW'(100 + idx); d_ready = (c % 2 == 0);
      @(negedge clk);
      fire = u_valid && u_ready;
      next_cycle();
      if (fire) idx++;
    end
    u_valid = 1'b0; d_ready = 1'b1;
    check("alt_count", out_count - base, 40);
    check("alt_last", last_out, 139);

    repeat (3) next_cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
